// File: rtl/hs_skid_slice.sv
// Two-entry registered valid/ready slice: every output is a flop or a decode of
// the state register, so neither side sees a combinational path from the other.
module hs_skid_slice #(
    parameter int DW    = 3,
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state, state_nxt;
    logic [DW-1:0]   main_q, main_nxt;
    logic [DW-1:0]   skid_q, skid_nxt;
    logic            s_fire, m_fire;

    assign m_valid = (state != EMPTY);
    assign s_ready = (state != FULL);
    assign m_data  = main_q;
    assign s_fire  = s_valid & s_ready;
    assign m_fire  = m_valid & m_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            EMPTY: begin
                if (s_fire) begin
                    main_nxt  = s_data;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                case ({s_fire, m_fire})
                    2'b10: begin
                        skid_nxt  = s_data;
                        state_nxt = FULL;
                    end
                    2'b01:   state_nxt = EMPTY;
                    2'b11:   main_nxt  = s_data;
                    default: ;
                endcase
            end
            FULL: begin
                // s_ready is low here, so the skid entry is the only candidate
                if (m_fire) begin
                    main_nxt  = skid_q;
                    state_nxt = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (m_fire)
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            // stall counter sticks at all-ones rather than wrapping
            if (m_valid && !m_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hs_skid_slice.sv
// Directed bench for hs_skid_slice with hand-computed expectations.
module tb_hs_skid_slice;

    localparam int DW    = 3;
    localparam int CNT_W = 8;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] xfer_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int errs   = 0;
    int checks = 0;

    hs_skid_slice #(.DW(DW), .CNT_W(CNT_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy),
        .xfer_cnt  (xfer_cnt),
        .stall_cnt (stall_cnt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one edge and settle 1ns past it
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        s_data    = '0;
        sys_rst_n = 1'b0;
        #2;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        // reset state, checked while reset is held
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        s_data    = '0;
        sys_rst_n = 1'b0;
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_xfer", xfer_cnt, 0);
        chk("rst_stall", stall_cnt, 0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_m_valid", m_valid, 0);
        chk("idle_s_ready", s_ready, 1);
        chk("idle_occ", occupancy, 0);
        chk("idle_xfer", xfer_cnt, 0);
        chk("idle_stall", stall_cnt, 0);

        // streaming 1..5, each beat visible the cycle after acceptance
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            tick();
            chk("stream_valid", m_valid, 1);
            chk("stream_data", m_data, i);
            chk("stream_occ", occupancy, 1);
        end
        s_valid = 1'b0;
        tick();
        chk("stream_drain_valid", m_valid, 0);
        chk("stream_xfer", xfer_cnt, 5);
        chk("stream_stall", stall_cnt, 0);

        // backpressure: beat 2 lands in skid, beat 3 waits upstream
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 3'd1;
        tick();
        chk("bp_first", m_data, 1);
        m_ready = 1'b0;
        s_data  = 3'd2;
        tick();
        chk("bp_occ_full", occupancy, 2);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_hold1", m_data, 1);
        s_data = 3'd3;
        tick();
        chk("bp_hold2", m_data, 1);
        chk("bp_still_full", occupancy, 2);
        chk("bp_stall", stall_cnt, 2);
        m_ready = 1'b1;
        tick();
        chk("bp_out2", m_data, 2);
        chk("bp_occ_busy", occupancy, 1);
        chk("bp_s_ready_back", s_ready, 1);
        tick();
        chk("bp_out3", m_data, 3);
        s_data = 3'd4;
        tick();
        chk("bp_out4", m_data, 4);
        s_valid = 1'b0;
        tick();
        chk("bp_drain_valid", m_valid, 0);
        chk("bp_xfer", xfer_cnt, 4);

        // stall counter saturation
        do_reset();
        s_valid = 1'b1;
        s_data  = 3'd7;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        chk("stall_254", stall_cnt, 254);
        for (int i = 0; i < 46; i++) tick();
        chk("stall_sat", stall_cnt, 255);
        chk("stall_xfer0", xfer_cnt, 0);
        chk("stall_data", m_data, 7);
        m_ready = 1'b1;
        tick();
        chk("stall_rel_xfer", xfer_cnt, 1);
        chk("stall_rel_valid", m_valid, 0);
        chk("stall_rel_hold", stall_cnt, 255);

        // asynchronous reset while FULL
        do_reset();
        s_valid = 1'b1;
        s_data  = 3'd1;
        tick();
        s_data = 3'd2;
        tick();
        chk("ar_full", occupancy, 2);
        s_valid = 1'b0;
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("ar_m_valid", m_valid, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_s_ready", s_ready, 1);
        chk("ar_xfer", xfer_cnt, 0);
        chk("ar_stall", stall_cnt, 0);
        sys_rst_n = 1'b1;
        m_ready   = 1'b1;
        s_valid   = 1'b1;
        s_data    = 3'd6;
        tick();
        chk("ar_beat6_valid", m_valid, 1);
        chk("ar_beat6_data", m_data, 6);
        s_valid = 1'b0;
        tick();
        chk("ar_alone", m_valid, 0);
        chk("ar_alone_xfer", xfer_cnt, 1);

        // transfer counter wrap over 257 beats
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            s_data = DW'(i);
            tick();
        end
        chk("wrap_255", xfer_cnt, 255);
        s_data = 3'd5;
        tick();
        chk("wrap_0", xfer_cnt, 0);
        chk("wrap_last_data", m_data, 5);
        s_valid = 1'b0;
        tick();
        chk("wrap_1", xfer_cnt, 1);
        chk("wrap_stall", stall_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
